// File: rtl/sockit_spi_dma_master.sv
// AXI4 initiator DMA for the SPI master: memory <-> SPI data streams.
// Issues INCR bursts clipped to BL beats and to 4 KB pages.
module sockit_spi_dma_master #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 4,
    parameter int BL = 16,
    parameter int ID = 0
)(
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic          cmd_dir,
    input  logic [AW-1:0] cmd_adr,
    input  logic [15:0]   cmd_len,
    output logic          sts_done,
    output logic          sts_err,
    output logic          ARVALID,
    input  logic          ARREADY,
    output logic [AW-1:0] ARADDR,
    output logic [7:0]    ARLEN,
    output logic [2:0]    ARSIZE,
    output logic [1:0]    ARBURST,
    output logic [IW-1:0] ARID,
    input  logic          RVALID,
    output logic          RREADY,
    input  logic [DW-1:0] RDATA,
    input  logic [1:0]    RRESP,
    input  logic          RLAST,
    input  logic [IW-1:0] RID,
    output logic          AWVALID,
    input  logic          AWREADY,
    output logic [AW-1:0] AWADDR,
    output logic [7:0]    AWLEN,
    output logic [2:0]    AWSIZE,
    output logic [1:0]    AWBURST,
    output logic [IW-1:0] AWID,
    output logic          WVALID,
    input  logic          WREADY,
    output logic [DW-1:0] WDATA,
    output logic [DW/8-1:0] WSTRB,
    output logic          WLAST,
    input  logic          BVALID,
    output logic          BREADY,
    input  logic [1:0]    BRESP,
    input  logic [IW-1:0] BID,
    output logic          sdw_vld,
    output logic [DW-1:0] sdw_dat,
    input  logic          sdw_rdy,
    input  logic          sdr_vld,
    input  logic [DW-1:0] sdr_dat,
    output logic          sdr_rdy
);

    localparam int SH = $clog2(DW/8);

    typedef enum logic [2:0] {
        IDLE, RADR, RDAT, WADR, WDAT, WRSP, DONE
    } state_t;

    state_t        st, st_d;
    logic [AW-1:0] adr, adr_d, step;
    logic [15:0]   rem, rem_d;
    logic [8:0]    len, len_d, cnt, cnt_d;
    logic          err, err_d;
    logic [12:0]   bnd;
    logic          unused;

    // one transaction outstanding at a time, so IDs carry no information
    assign unused = ^{RID, BID};
    assign step   = AW'(len) << SH;

    always_comb begin
        st_d  = st;
        adr_d = adr;
        rem_d = rem;
        cnt_d = cnt;
        err_d = err;
        unique case (st)
            IDLE: if (cmd_vld) begin
                adr_d = cmd_adr;
                rem_d = cmd_len;
                err_d = 1'b0;
                cnt_d = '0;
                if (cmd_len == 16'd0) st_d = DONE;
                else if (cmd_dir)     st_d = WADR;
                else                  st_d = RADR;
            end
            RADR: if (ARREADY) st_d = RDAT;
            RDAT: if (RVALID && sdw_rdy) begin
                if (RRESP != 2'b00) err_d = 1'b1;
                if (RLAST) begin
                    adr_d = adr + step;
                    rem_d = rem - 16'(len);
                    st_d  = (rem_d == 16'd0 || err_d) ? DONE : RADR;
                end
            end
            WADR: if (AWREADY) st_d = WDAT;
            WDAT: if (sdr_vld && WREADY) begin
                if (cnt == len - 9'd1) begin
                    cnt_d = '0;
                    st_d  = WRSP;
                end else begin
                    cnt_d = cnt + 9'd1;
                end
            end
            WRSP: if (BVALID) begin
                if (BRESP != 2'b00) err_d = 1'b1;
                adr_d = adr + step;
                rem_d = rem - 16'(len);
                st_d  = (rem_d == 16'd0 || err_d) ? DONE : WADR;
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
        // next burst length: min(remaining, BL, words left in the 4 KB page)
        bnd   = (13'h1000 - {1'b0, adr_d[11:0]}) >> SH;
        len_d = 9'(BL);
        if ({4'b0, len_d} > bnd) len_d = bnd[8:0];
        if (rem_d < {7'b0, len_d}) len_d = rem_d[8:0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            st  <= IDLE;
            adr <= '0;
            rem <= '0;
            len <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            st  <= st_d;
            adr <= adr_d;
            rem <= rem_d;
            len <= len_d;
            cnt <= cnt_d;
            err <= err_d;
        end
    end

    assign cmd_rdy  = (st == IDLE) & ~ARESET;
    assign sts_done = (st == DONE);
    assign sts_err  = err;

    assign ARVALID = (st == RADR);
    assign ARADDR  = adr;
    assign ARLEN   = 8'(len - 9'd1);
    assign ARSIZE  = 3'(SH);
    assign ARBURST = 2'b01;
    assign ARID    = IW'(ID);
    assign RREADY  = (st == RDAT) & sdw_rdy;
    assign sdw_vld = (st == RDAT) & RVALID;
    assign sdw_dat = RDATA;

    assign AWVALID = (st == WADR);
    assign AWADDR  = adr;
    assign AWLEN   = 8'(len - 9'd1);
    assign AWSIZE  = 3'(SH);
    assign AWBURST = 2'b01;
    assign AWID    = IW'(ID);
    assign WVALID  = (st == WDAT) & sdr_vld;
    assign WDATA   = sdr_dat;
    assign WSTRB   = '1;
    assign WLAST   = (st == WDAT) && (cnt == len - 9'd1);
    assign sdr_rdy = (st == WDAT) & WREADY;
    assign BREADY  = (st == WRSP);

endmodule
